// File: rtl/dm_mmio_responder_if.sv
// Data-memory port bundle between the core (plus TX consumer) and the responder.
interface dm_mmio_responder_if;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  // Core and TX consumer side.
  modport master (
    output MemWrite,
    output addr,
    output writedata,
    output out_ready,
    input  readdata,
    input  out_valid,
    input  out_data
  );

  // Responder side.
  modport slave (
    input  MemWrite,
    input  addr,
    input  writedata,
    input  out_ready,
    output readdata,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/dm_mmio_responder.sv
// Data-memory responder: word RAM plus an MMIO window with a TX FIFO and a cycle timer.
// Loads are combinational; stores and MMIO side effects take effect on the rising edge.
module dm_mmio_responder #(
  parameter int unsigned DM_DEPTH   = 128,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_7F00
) (
  input logic                clk,
  input logic                rst,
  dm_mmio_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DM_DEPTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [5:0] OffTxData = 6'd0;
  localparam logic [5:0] OffStatus = 6'd1;
  localparam logic [5:0] OffTimer  = 6'd2;

  logic [31:0]   ram [DM_DEPTH];
  logic [31:0]   fifo_mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic [31:0]   timer;

  logic          mmio;
  logic [5:0]    off;
  logic [AW-1:0] ram_idx;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          pop;
  logic          push_ok;
  logic          ovf_set;
  logic          ovf_clr;
  logic          timer_wr;
  logic [31:0]   status;
  logic          unused_addr;

  assign mmio    = (bus.addr[31:8] == MMIO_BASE[31:8]);
  assign off     = bus.addr[7:2];
  assign ram_idx = bus.addr[AW+1:2];
  // Byte-lane bits carry no meaning for a word-only port.
  assign unused_addr = ^bus.addr[1:0];

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));

  assign push_req = bus.MemWrite && mmio && (off == OffTxData);
  assign pop      = !empty && bus.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = bus.MemWrite && mmio && (off == OffStatus) && bus.writedata[2];
  assign timer_wr = bus.MemWrite && mmio && (off == OffTimer);

  assign status = {16'b0, 8'(count), 5'b0, ovf, full, empty};

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? 32'h0 : fifo_mem[rd_ptr];

  // Combinational load path: MMIO register or RAM word.
  always_comb begin
    bus.readdata = 32'h0;
    if (mmio) begin
      case (off)
        OffStatus: bus.readdata = status;
        OffTimer:  bus.readdata = timer;
        default:   bus.readdata = 32'h0;
      endcase
    end else begin
      bus.readdata = ram[ram_idx];
    end
  end

  // RAM store; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && !mmio) begin
      ram[ram_idx] <= bus.writedata;
    end
  end

  // FIFO storage; only the pointers and count need reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= bus.writedata;
    end
  end

  // FIFO control, sticky overflow flag and free-running timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      timer  <= 32'h0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set has priority over clear.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      // A loaded value is presented as-is for one cycle before counting resumes.
      if (timer_wr) begin
        timer <= bus.writedata;
      end else begin
        timer <= timer + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dm_mmio_responder.sv
// Self-checking bench for dm_mmio_responder; TX words tracked in a scoreboard queue.
module tb_dm_mmio_responder;
  localparam int unsigned DM_DEPTH   = 128;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam logic [31:0] MMIO_BASE  = 32'h0000_7F00;
  localparam logic [31:0] A_TX  = MMIO_BASE;
  localparam logic [31:0] A_ST  = MMIO_BASE + 32'h4;
  localparam logic [31:0] A_TM  = MMIO_BASE + 32'h8;
  localparam logic [31:0] A_RSV = MMIO_BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  dm_mmio_responder_if bus();

  dm_mmio_responder #(
    .DM_DEPTH   (DM_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MMIO_BASE  (MMIO_BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.MemWrite = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite = 1'b1;
    bus.addr = a;
    bus.writedata = d;
    tick();
    bus.MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 32'h0) begin
      errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data);
    end
    rd(A_ST, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL reset_status: got %h want 00000001", v); end
    rd(A_TM, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_timer: got %h want 0", v); end
  endtask

  task automatic test_ram();
    logic [31:0] v;
    do_reset();
    store(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd: got %h want deadbeef", v); end
    rd(32'h10 + 4 * DM_DEPTH, v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias: got %h want deadbeef", v); end
    store(32'h14, 32'h1234_5678);
    rd(32'h10, v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_neighbor: got %h want deadbeef", v); end
    rd(32'h17, v);
    checks++;
    if (v !== 32'h1234_5678) begin errors++; $display("FAIL ram_lowbits: got %h want 12345678", v); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    do_reset();
    rd(A_TM, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL timer_c0: got %h want 0", v); end
    tick();
    rd(A_TM, v);
    checks++;
    if (v !== 32'd1) begin errors++; $display("FAIL timer_c1: got %h want 1", v); end
    repeat (4) tick();
    rd(A_TM, v);
    checks++;
    if (v !== 32'd5) begin errors++; $display("FAIL timer_c5: got %h want 5", v); end
    store(A_TM, 32'hFFFF_FFFE);
    rd(A_TM, v);
    checks++;
    if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL timer_load: got %h want fffffffe", v); end
    tick();
    rd(A_TM, v);
    checks++;
    if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timer_inc: got %h want ffffffff", v); end
    tick();
    rd(A_TM, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL timer_wrap: got %h want 0", v); end
  endtask

  task automatic test_fill_ovf();
    logic [31:0] v;
    do_reset();
    for (int i = 1; i <= FIFO_DEPTH; i++) begin
      if (i == 1) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++; $display("FAIL fill_pre_valid: got %b want 0", bus.out_valid);
        end
      end
      store(A_TX, 32'(i));
      exp_q.push_back(32'(i));
      if (i == 1) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin
          errors++; $display("FAIL fill_post_valid: got %b want 1", bus.out_valid);
        end
      end
    end
    rd(A_ST, v);
    checks++;
    if (v !== 32'h0000_0802) begin errors++; $display("FAIL fill_status: got %h want 00000802", v); end
    store(A_TX, 32'd9);
    rd(A_ST, v);
    checks++;
    if (v !== 32'h0000_0806) begin errors++; $display("FAIL ovf_status: got %h want 00000806", v); end
    checks++;
    if (bus.out_data !== exp_q[0]) begin
      errors++; $display("FAIL ovf_head: got %h want %h", bus.out_data, exp_q[0]);
    end
    rd(A_TX, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL txdata_rd: got %h want 0", v); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] v;
    int          n;
    do_reset();
    for (int i = 1; i <= FIFO_DEPTH; i++) begin
      store(A_TX, 32'(i));
      exp_q.push_back(32'(i));
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.out_data !== exp_q[0]) begin
      errors++; $display("FAIL fpp_head: got %h want %h", bus.out_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    exp_q.push_back(32'd9);
    store(A_TX, 32'd9);
    bus.out_ready = 1'b0;
    rd(A_ST, v);
    checks++;
    if (v !== 32'h0000_0802) begin errors++; $display("FAIL fpp_status: got %h want 00000802", v); end
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.out_valid === 1'b1 && n < 4 * FIFO_DEPTH) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL fpp_extra: got %h want no word", bus.out_data);
      end else begin
        v = exp_q.pop_front();
        if (bus.out_data !== v) begin
          errors++; $display("FAIL fpp_drain: got %h want %h", bus.out_data, v);
        end
      end
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fpp_drained: got %0d left valid %b want 0 left valid 0", exp_q.size(),
               bus.out_valid);
    end
    rd(A_ST, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL fpp_empty_status: got %h want 00000001", v); end
  endtask

  task automatic test_ovf_clear();
    logic [31:0] v;
    do_reset();
    for (int i = 0; i <= FIFO_DEPTH; i++) store(A_TX, 32'(i + 100));
    store(A_ST, 32'hFFFF_FFFB);
    rd(A_ST, v);
    checks++;
    if (v !== 32'h0000_0806) begin errors++; $display("FAIL ovf_noclr: got %h want 00000806", v); end
    store(A_ST, 32'h4);
    rd(A_ST, v);
    checks++;
    if (v !== 32'h0000_0802) begin errors++; $display("FAIL ovf_clr: got %h want 00000802", v); end
    store(A_RSV, 32'h55);
    rd(A_RSV, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL rsv_rd: got %h want 0", v); end
    store(A_TX, 32'h77);
    rd(A_ST, v);
    checks++;
    if (v !== 32'h0000_0806) begin errors++; $display("FAIL ovf_reset: got %h want 00000806", v); end
    checks++;
    if (bus.out_data !== 32'd100) begin
      errors++; $display("FAIL ovf_keep_head: got %h want 00000064", bus.out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int          n;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid === 1'b1) begin
        checks++;
        v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hX;
        if (bus.out_data !== v) begin
          errors++; $display("FAIL b2b_word: got %h want %h", bus.out_data, v);
        end
      end
      exp_q.push_back(32'hA000_0000 + 32'(i));
      store(A_TX, 32'hA000_0000 + 32'(i));
    end
    bus.out_ready = 1'b0;
    rd(A_ST, v);
    checks++;
    if (v !== 32'h0000_0100) begin errors++; $display("FAIL b2b_status: got %h want 00000100", v); end
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.out_valid === 1'b1 && n < 4 * FIFO_DEPTH) begin
      checks++;
      v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hX;
      if (bus.out_data !== v) begin
        errors++; $display("FAIL b2b_drain: got %h want %h", bus.out_data, v);
      end
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_left: got %0d words want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] v;
    do_reset();
    store(32'h40, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) store(A_TX, 32'(i + 1));
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_valid: got %b want 0", bus.out_valid);
    end
    rd(A_ST, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL mid_status: got %h want 00000001", v); end
    rd(A_TM, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL mid_timer: got %h want 0", v); end
    rd(32'h40, v);
    checks++;
    if (v !== 32'hCAFE_F00D) begin errors++; $display("FAIL mid_ram: got %h want cafef00d", v); end
  endtask

  initial begin
    bus.MemWrite  = 1'b0;
    bus.addr      = 32'h0;
    bus.writedata = 32'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_ram();
    test_timer();
    test_fill_ovf();
    test_full_push_pop();
    test_ovf_clear();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
